// File: rtl/ahb_pipelined_master.sv
// AHB-Lite master that queues commands in a FIFO and issues them as pipelined SINGLE
// transfers, with two-cycle ERROR cancel-and-replay and one response per command.
module ahb_pipelined_master #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR       = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rstn_ahb,
  input  logic                  i_hready,
  input  logic                  i_hresp,
  input  logic [DATA_WIDTH-1:0] i_hrdata,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR-1:0]       i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd0_wr1,
  input  logic [2:0]            i_size,
  output logic [ADDR-1:0]       o_haddr,
  output logic [1:0]            o_htrans,
  output logic                  o_hwrite,
  output logic [2:0]            o_hsize,
  output logic [2:0]            o_hburst,
  output logic [3:0]            o_hprot,
  output logic                  o_hmastlock,
  output logic [DATA_WIDTH-1:0] o_hwdata,
  output logic                  o_rsp_valid,
  output logic                  o_rsp_rd0_wr1,
  output logic                  o_rsp_err,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_busy
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [2:0]       MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR-1:0]       addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wr;
    logic [2:0]            size;
  } cmd_t;

  typedef enum logic [1:0] {A_IDLE, A_NONSEQ, A_CANCEL} astate_e;

  cmd_t                  fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  push, pop, fifo_empty, fifo_full;
  cmd_t                  head;
  logic [2:0]            head_size;

  astate_e               state_q, state_d;
  logic [ADDR-1:0]       haddr_q, haddr_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [DATA_WIDTH-1:0] awdata_q, awdata_d;
  logic                  load, accept, err_first;

  logic                  dvalid_q, dwrite_q;
  logic [DATA_WIDTH-1:0] dwdata_q;
  logic                  rsp_valid_q, rsp_wr_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign push       = i_valid && !fifo_full;
  assign pop        = load;
  assign head       = fifo_mem_q[rd_ptr_q];
  assign head_size  = (head.size > MAX_SIZE) ? MAX_SIZE : head.size;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk_ahb) begin
    if (push) fifo_mem_q[wr_ptr_q] <= '{addr: i_addr, wdata: i_wr_data, wr: i_rd0_wr1, size: i_size};
  end

  // While the data stage sits in the first ERROR cycle nothing new may be issued, so
  // the address stage parks in A_CANCEL (or stays idle) and keeps its command.
  assign accept    = (state_q == A_NONSEQ) && i_hready;
  assign err_first = dvalid_q && i_hresp && !i_hready;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    awdata_d = awdata_q;
    case (state_q)
      A_IDLE: begin
        if (!fifo_empty && !err_first) begin
          state_d = A_NONSEQ;
          load    = 1'b1;
        end
      end
      A_NONSEQ: begin
        if (err_first) begin
          state_d = A_CANCEL;
        end else if (i_hready) begin
          if (!fifo_empty) load = 1'b1;
          else             state_d = A_IDLE;
        end
      end
      A_CANCEL: state_d = A_NONSEQ;
      default:  state_d = A_IDLE;
    endcase
    if (load) begin
      haddr_d  = head.addr;
      hwrite_d = head.wr;
      hsize_d  = head_size;
      awdata_d = head.wdata;
    end
  end

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      state_q  <= A_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      awdata_q <= '0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      awdata_q <= awdata_d;
    end
  end

  // Data stage and response: a phase completes on any edge with HREADY high.
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      dvalid_q    <= 1'b0;
      dwrite_q    <= 1'b0;
      dwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rsp_valid_q <= dvalid_q && i_hready;
      if (dvalid_q && i_hready) begin
        rsp_wr_q  <= dwrite_q;
        rsp_err_q <= i_hresp;
        if (!dwrite_q) rd_data_q <= i_hrdata;
      end
      if (accept) begin
        dvalid_q <= 1'b1;
        dwrite_q <= hwrite_q;
        dwdata_q <= awdata_q;
      end else if (i_hready) begin
        dvalid_q <= 1'b0;
      end
    end
  end

  assign o_ready       = !fifo_full;
  assign o_haddr       = haddr_q;
  assign o_htrans      = (state_q == A_NONSEQ) ? 2'b10 : 2'b00;
  assign o_hwrite      = hwrite_q;
  assign o_hsize       = hsize_q;
  assign o_hburst      = 3'b000;
  assign o_hprot       = HPROT_VAL;
  assign o_hmastlock   = 1'b0;
  assign o_hwdata      = (dvalid_q && dwrite_q) ? dwdata_q : '0;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rd0_wr1 = rsp_wr_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_rd_data     = rd_data_q;
  assign o_busy        = !fifo_empty || (state_q != A_IDLE) || dvalid_q;

endmodule

// File: tb/tb_ahb_pipelined_master.sv
// Directed testbench for ahb_pipelined_master: per-cycle stimulus tables with
// hand-derived expected bus and response behaviour for each scenario.
module tb_ahb_pipelined_master;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int NCYC = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_hready = 1'b1, i_hresp = 1'b0;
  logic [DW-1:0] i_hrdata = '0;
  logic          i_valid = 1'b0, i_rd0_wr1 = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_wr_data = '0;
  logic [2:0]    i_size = 3'd2;
  logic          o_ready, o_hwrite, o_hmastlock, o_rsp_valid, o_rsp_rd0_wr1, o_rsp_err, o_busy;
  logic [AW-1:0] o_haddr;
  logic [1:0]    o_htrans;
  logic [2:0]    o_hsize, o_hburst;
  logic [3:0]    o_hprot;
  logic [DW-1:0] o_hwdata, o_rd_data;

  int checks = 0;
  int failures = 0;

  logic          st_valid [NCYC];
  logic [AW-1:0] st_addr [NCYC];
  logic [DW-1:0] st_data [NCYC];
  logic          st_wr [NCYC];
  logic [2:0]    st_size [NCYC];
  logic          st_hready [NCYC];
  logic          st_hresp [NCYC];

  logic [1:0]    lg_htrans [NCYC];
  logic [AW-1:0] lg_haddr [NCYC];
  logic          lg_hwrite [NCYC];
  logic [2:0]    lg_hsize [NCYC];
  logic [DW-1:0] lg_hwdata [NCYC];
  logic          lg_rsp_valid [NCYC];
  logic          lg_rsp_wr [NCYC];
  logic          lg_rsp_err [NCYC];
  logic [DW-1:0] lg_rd_data [NCYC];
  logic          lg_busy [NCYC];
  logic          lg_ready [NCYC];

  always #5 clk = ~clk;

  ahb_pipelined_master #(.DATA_WIDTH(DW), .ADDR(AW), .FIFO_DEPTH(4), .HPROT_VAL(4'b0011)) dut (
    .i_clk_ahb(clk), .i_rstn_ahb(rstn), .i_hready(i_hready), .i_hresp(i_hresp),
    .i_hrdata(i_hrdata), .i_valid(i_valid), .o_ready(o_ready), .i_addr(i_addr),
    .i_wr_data(i_wr_data), .i_rd0_wr1(i_rd0_wr1), .i_size(i_size), .o_haddr(o_haddr),
    .o_htrans(o_htrans), .o_hwrite(o_hwrite), .o_hsize(o_hsize), .o_hburst(o_hburst),
    .o_hprot(o_hprot), .o_hmastlock(o_hmastlock), .o_hwdata(o_hwdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rd0_wr1(o_rsp_rd0_wr1), .o_rsp_err(o_rsp_err),
    .o_rd_data(o_rd_data), .o_busy(o_busy)
  );

  task automatic clear_stim();
    for (int i = 0; i < NCYC; i++) begin
      st_valid[i] = 1'b0; st_addr[i] = '0; st_data[i] = '0; st_wr[i] = 1'b0;
      st_size[i] = 3'd2; st_hready[i] = 1'b1; st_hresp[i] = 1'b0;
    end
  endtask

  task automatic set_cmd(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic wr, input logic [2:0] sz);
    st_valid[c] = 1'b1; st_addr[c] = a; st_data[c] = d; st_wr[c] = wr; st_size[c] = sz;
  endtask

  // Cycle c: inputs driven 1ns after edge c, outputs logged at the falling edge.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      i_valid = st_valid[c]; i_addr = st_addr[c]; i_wr_data = st_data[c];
      i_rd0_wr1 = st_wr[c]; i_size = st_size[c]; i_hready = st_hready[c]; i_hresp = st_hresp[c];
      @(negedge clk);
      lg_htrans[c] = o_htrans; lg_haddr[c] = o_haddr; lg_hwrite[c] = o_hwrite;
      lg_hsize[c] = o_hsize; lg_hwdata[c] = o_hwdata; lg_rsp_valid[c] = o_rsp_valid;
      lg_rsp_wr[c] = o_rsp_rd0_wr1; lg_rsp_err[c] = o_rsp_err; lg_rd_data[c] = o_rd_data;
      lg_busy[c] = o_busy; lg_ready[c] = o_ready;
    end
    i_valid = 1'b0; i_hready = 1'b1; i_hresp = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (o_htrans !== 2'b00) begin failures++; $display("FAIL reset_htrans: got %0h expected 0", o_htrans); end
    checks++; if (o_haddr !== '0) begin failures++; $display("FAIL reset_haddr: got %0h expected 0", o_haddr); end
    checks++; if (o_hwdata !== '0) begin failures++; $display("FAIL reset_hwdata: got %0h expected 0", o_hwdata); end
    checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %0b expected 0", o_rsp_valid); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", o_busy); end
    checks++; if (o_rd_data !== '0) begin failures++; $display("FAIL reset_rd_data: got %0h expected 0", o_rd_data); end
    checks++; if (o_hburst !== 3'b000 || o_hprot !== 4'b0011 || o_hmastlock !== 1'b0) begin
      failures++; $display("FAIL reset_consts: got hburst %0h hprot %0h hmastlock %0b expected 0 3 0", o_hburst, o_hprot, o_hmastlock);
    end
    #9 rstn = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b expected 1", o_ready); end
  endtask

  task automatic test_single_write();
    clear_stim();
    set_cmd(0, 32'h5, 32'hA1A2A3A4, 1'b1, 3'd2);
    run_cycles(6);
    checks++; if (lg_htrans[1] !== 2'b00) begin failures++; $display("FAIL single_idle_c1: got %0h expected 0", lg_htrans[1]); end
    checks++; if (lg_htrans[2] !== 2'b10 || lg_haddr[2] !== 32'h5 || lg_hwrite[2] !== 1'b1) begin
      failures++; $display("FAIL single_addr_phase: got htrans %0h haddr %0h hwrite %0b expected 2 5 1", lg_htrans[2], lg_haddr[2], lg_hwrite[2]);
    end
    checks++; if (lg_hwdata[3] !== 32'hA1A2A3A4 || lg_htrans[3] !== 2'b00) begin
      failures++; $display("FAIL single_data_phase: got hwdata %0h htrans %0h expected a1a2a3a4 0", lg_hwdata[3], lg_htrans[3]);
    end
    checks++; if (lg_haddr[3] !== 32'h5) begin failures++; $display("FAIL single_haddr_hold: got %0h expected 5", lg_haddr[3]); end
    checks++; if (lg_rsp_valid[3] !== 1'b0 || lg_rsp_valid[4] !== 1'b1 || lg_rsp_valid[5] !== 1'b0) begin
      failures++; $display("FAIL single_rsp_timing: got c3 %0b c4 %0b c5 %0b expected 0 1 0", lg_rsp_valid[3], lg_rsp_valid[4], lg_rsp_valid[5]);
    end
    checks++; if (lg_rsp_wr[4] !== 1'b1 || lg_rsp_err[4] !== 1'b0) begin
      failures++; $display("FAIL single_rsp_fields: got wr %0b err %0b expected 1 0", lg_rsp_wr[4], lg_rsp_err[4]);
    end
    checks++; if (lg_busy[1] !== 1'b1 || lg_busy[5] !== 1'b0) begin
      failures++; $display("FAIL single_busy: got c1 %0b c5 %0b expected 1 0", lg_busy[1], lg_busy[5]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_trans [8];
    logic       exp_rsp [8];
    exp_trans = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    exp_rsp   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    clear_stim();
    i_hrdata = 32'hABCD1234;
    set_cmd(0, 32'h5, 32'h11111111, 1'b1, 3'd2);
    set_cmd(1, 32'h7, 32'h0, 1'b0, 3'd2);
    set_cmd(2, 32'h6, 32'h22222222, 1'b1, 3'd2);
    run_cycles(8);
    for (int c = 0; c < 8; c++) begin
      checks++; if (lg_htrans[c] !== exp_trans[c]) begin failures++; $display("FAIL b2b_htrans_c%0d: got %0h expected %0h", c, lg_htrans[c], exp_trans[c]); end
      checks++; if (lg_rsp_valid[c] !== exp_rsp[c]) begin failures++; $display("FAIL b2b_rsp_valid_c%0d: got %0b expected %0b", c, lg_rsp_valid[c], exp_rsp[c]); end
    end
    checks++; if (lg_haddr[2] !== 32'h5 || lg_haddr[3] !== 32'h7 || lg_haddr[4] !== 32'h6) begin
      failures++; $display("FAIL b2b_haddr: got %0h %0h %0h expected 5 7 6", lg_haddr[2], lg_haddr[3], lg_haddr[4]);
    end
    checks++; if (lg_hwdata[3] !== 32'h11111111 || lg_hwdata[4] !== 32'h0 || lg_hwdata[5] !== 32'h22222222) begin
      failures++; $display("FAIL b2b_hwdata: got %0h %0h %0h expected 11111111 0 22222222", lg_hwdata[3], lg_hwdata[4], lg_hwdata[5]);
    end
    checks++; if (lg_rsp_wr[4] !== 1'b1 || lg_rsp_wr[5] !== 1'b0 || lg_rsp_wr[6] !== 1'b1) begin
      failures++; $display("FAIL b2b_rsp_order: got %0b %0b %0b expected 1 0 1", lg_rsp_wr[4], lg_rsp_wr[5], lg_rsp_wr[6]);
    end
    checks++; if (lg_rd_data[5] !== 32'hABCD1234) begin failures++; $display("FAIL b2b_rd_data: got %0h expected abcd1234", lg_rd_data[5]); end
  endtask

  task automatic test_wait_states();
    int xfers;
    clear_stim();
    i_hrdata = 32'hABCD1234;
    set_cmd(0, 32'h5, 32'h11111111, 1'b1, 3'd2);
    set_cmd(1, 32'h7, 32'h0, 1'b0, 3'd2);
    set_cmd(2, 32'h6, 32'h22222222, 1'b1, 3'd2);
    st_hready[4] = 1'b0;
    st_hready[5] = 1'b0;
    run_cycles(10);
    for (int c = 4; c <= 6; c++) begin
      checks++; if (lg_htrans[c] !== 2'b10 || lg_haddr[c] !== 32'h6 || lg_hwdata[c] !== 32'h0) begin
        failures++; $display("FAIL wait_hold_c%0d: got htrans %0h haddr %0h hwdata %0h expected 2 6 0", c, lg_htrans[c], lg_haddr[c], lg_hwdata[c]);
      end
    end
    checks++; if (lg_rsp_valid[5] !== 1'b0 || lg_rsp_valid[6] !== 1'b0 || lg_rsp_valid[7] !== 1'b1) begin
      failures++; $display("FAIL wait_read_rsp: got c5 %0b c6 %0b c7 %0b expected 0 0 1", lg_rsp_valid[5], lg_rsp_valid[6], lg_rsp_valid[7]);
    end
    checks++; if (lg_rsp_wr[7] !== 1'b0 || lg_rd_data[7] !== 32'hABCD1234) begin
      failures++; $display("FAIL wait_read_data: got wr %0b data %0h expected 0 abcd1234", lg_rsp_wr[7], lg_rd_data[7]);
    end
    checks++; if (lg_hwdata[7] !== 32'h22222222 || lg_rsp_valid[8] !== 1'b1 || lg_rsp_wr[8] !== 1'b1) begin
      failures++; $display("FAIL wait_last_write: got hwdata %0h rsp %0b wr %0b expected 22222222 1 1", lg_hwdata[7], lg_rsp_valid[8], lg_rsp_wr[8]);
    end
    xfers = 0;
    for (int c = 0; c < 10; c++) if (lg_htrans[c] == 2'b10 && st_hready[c]) xfers++;
    checks++; if (xfers != 3) begin failures++; $display("FAIL wait_xfer_count: got %0d expected 3", xfers); end
  endtask

  task automatic test_fifo_full();
    int rsps;
    clear_stim();
    for (int i = 0; i < 6; i++) set_cmd(i, 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b1, 3'd2);
    for (int c = 0; c < 7; c++) st_hready[c] = 1'b0;
    run_cycles(16);
    for (int c = 0; c < 5; c++) begin
      checks++; if (lg_ready[c] !== 1'b1) begin failures++; $display("FAIL full_ready_c%0d: got %0b expected 1", c, lg_ready[c]); end
    end
    checks++; if (lg_ready[5] !== 1'b0 || lg_ready[6] !== 1'b0) begin
      failures++; $display("FAIL full_ready_low: got c5 %0b c6 %0b expected 0 0", lg_ready[5], lg_ready[6]);
    end
    checks++; if (lg_htrans[5] !== 2'b10 || lg_haddr[5] !== 32'h100) begin
      failures++; $display("FAIL full_addr_stall: got htrans %0h haddr %0h expected 2 100", lg_htrans[5], lg_haddr[5]);
    end
    rsps = 0;
    for (int c = 0; c < 16; c++) if (lg_rsp_valid[c] === 1'b1) rsps++;
    checks++; if (rsps != 5) begin failures++; $display("FAIL full_rsp_count: got %0d expected 5", rsps); end
    checks++; if (lg_hwdata[12] !== 32'hC0DE0004) begin failures++; $display("FAIL full_last_hwdata: got %0h expected c0de0004", lg_hwdata[12]); end
    checks++; if (lg_busy[12] !== 1'b1 || lg_busy[13] !== 1'b0 || lg_rsp_valid[13] !== 1'b1) begin
      failures++; $display("FAIL full_busy_fall: got busy12 %0b busy13 %0b rsp13 %0b expected 1 0 1", lg_busy[12], lg_busy[13], lg_rsp_valid[13]);
    end
    checks++; if (lg_ready[15] !== 1'b1) begin failures++; $display("FAIL full_ready_back: got %0b expected 1", lg_ready[15]); end
  endtask

  task automatic test_error();
    int nonseq;
    clear_stim();
    i_hrdata = 32'hDEADBEEF;
    set_cmd(0, 32'h10, 32'h0, 1'b0, 3'd2);
    set_cmd(1, 32'h14, 32'h5A5A5A5A, 1'b1, 3'd2);
    st_hresp[3] = 1'b1; st_hready[3] = 1'b0;
    st_hresp[4] = 1'b1; st_hready[4] = 1'b1;
    run_cycles(9);
    checks++; if (lg_htrans[3] !== 2'b10 || lg_haddr[3] !== 32'h14) begin
      failures++; $display("FAIL err_pending_addr: got htrans %0h haddr %0h expected 2 14", lg_htrans[3], lg_haddr[3]);
    end
    checks++; if (lg_htrans[4] !== 2'b00 || lg_haddr[4] !== 32'h14) begin
      failures++; $display("FAIL err_cancel_idle: got htrans %0h haddr %0h expected 0 14", lg_htrans[4], lg_haddr[4]);
    end
    checks++; if (lg_rsp_valid[4] !== 1'b0 || lg_rsp_valid[5] !== 1'b1 || lg_rsp_err[5] !== 1'b1 || lg_rsp_wr[5] !== 1'b0) begin
      failures++; $display("FAIL err_read_rsp: got v4 %0b v5 %0b err %0b wr %0b expected 0 1 1 0", lg_rsp_valid[4], lg_rsp_valid[5], lg_rsp_err[5], lg_rsp_wr[5]);
    end
    checks++; if (lg_htrans[5] !== 2'b10 || lg_haddr[5] !== 32'h14 || lg_hwrite[5] !== 1'b1) begin
      failures++; $display("FAIL err_replay: got htrans %0h haddr %0h hwrite %0b expected 2 14 1", lg_htrans[5], lg_haddr[5], lg_hwrite[5]);
    end
    checks++; if (lg_hwdata[6] !== 32'h5A5A5A5A) begin failures++; $display("FAIL err_replay_hwdata: got %0h expected 5a5a5a5a", lg_hwdata[6]); end
    checks++; if (lg_rsp_valid[7] !== 1'b1 || lg_rsp_err[7] !== 1'b0 || lg_rsp_wr[7] !== 1'b1) begin
      failures++; $display("FAIL err_write_rsp: got v %0b err %0b wr %0b expected 1 0 1", lg_rsp_valid[7], lg_rsp_err[7], lg_rsp_wr[7]);
    end
    nonseq = 0;
    for (int c = 0; c < 9; c++) if (lg_htrans[c] == 2'b10) nonseq++;
    checks++; if (nonseq != 3) begin failures++; $display("FAIL err_nonseq_count: got %0d expected 3", nonseq); end
    checks++; if (lg_busy[8] !== 1'b0) begin failures++; $display("FAIL err_busy_end: got %0b expected 0", lg_busy[8]); end
  endtask

  task automatic test_size_clamp();
    clear_stim();
    i_hrdata = 32'h0BADF00D;
    set_cmd(0, 32'h20, 32'h0, 1'b0, 3'd7);
    set_cmd(1, 32'h24, 32'h0, 1'b0, 3'd1);
    run_cycles(7);
    checks++; if (lg_htrans[2] !== 2'b10 || lg_hsize[2] !== 3'd2 || lg_hwrite[2] !== 1'b0) begin
      failures++; $display("FAIL size_clamp: got htrans %0h hsize %0d hwrite %0b expected 2 2 0", lg_htrans[2], lg_hsize[2], lg_hwrite[2]);
    end
    checks++; if (lg_hsize[3] !== 3'd1 || lg_haddr[3] !== 32'h24) begin
      failures++; $display("FAIL size_legal: got hsize %0d haddr %0h expected 1 24", lg_hsize[3], lg_haddr[3]);
    end
    checks++; if (lg_rsp_valid[4] !== 1'b1 || lg_rsp_wr[4] !== 1'b0 || lg_rd_data[4] !== 32'h0BADF00D) begin
      failures++; $display("FAIL size_read_rsp: got v %0b wr %0b data %0h expected 1 0 badf00d", lg_rsp_valid[4], lg_rsp_wr[4], lg_rd_data[4]);
    end
  endtask

  task automatic test_reset_mid();
    int rsps;
    clear_stim();
    set_cmd(0, 32'h30, 32'h77, 1'b1, 3'd2);
    st_hready[3] = 1'b0;
    run_cycles(4);
    rstn = 1'b0;
    checks++; if (lg_hwdata[3] !== 32'h77) begin failures++; $display("FAIL rstmid_pre_hwdata: got %0h expected 77", lg_hwdata[3]); end
    #1;
    checks++; if (o_htrans !== 2'b00 || o_haddr !== '0 || o_hwrite !== 1'b0 || o_hsize !== 3'd0) begin
      failures++; $display("FAIL rstmid_addr_outs: got htrans %0h haddr %0h hwrite %0b hsize %0d expected 0 0 0 0", o_htrans, o_haddr, o_hwrite, o_hsize);
    end
    checks++; if (o_hwdata !== '0 || o_busy !== 1'b0 || o_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_data_outs: got hwdata %0h busy %0b rsp %0b expected 0 0 0", o_hwdata, o_busy, o_rsp_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    clear_stim();
    run_cycles(5);
    rsps = 0;
    for (int c = 0; c < 5; c++) if (lg_rsp_valid[c] !== 1'b0 || lg_htrans[c] !== 2'b00) rsps++;
    checks++; if (rsps != 0) begin failures++; $display("FAIL rstmid_no_activity: got %0d active cycles expected 0", rsps); end
    checks++; if (lg_ready[4] !== 1'b1 || lg_busy[4] !== 1'b0) begin
      failures++; $display("FAIL rstmid_idle_after: got ready %0b busy %0b expected 1 0", lg_ready[4], lg_busy[4]);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wait_states();
    test_fifo_full();
    test_error();
    test_size_clamp();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
